// File: rtl/uart_paddle_rx.sv
// ============================================================================
//  Module   : uart_paddle_rx
//  Function : UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) and
//             paddle command decoder driving held, retriggerable direction levels.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_paddle_rx #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BCW          = $clog2(CLKS_PER_BIT + 1);
    localparam int HCW          = $clog2(HOLD_CYCLES + 1);

    localparam logic [BCW-1:0] c_BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] c_HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [HCW-1:0] c_HOLD      = HCW'(HOLD_CYCLES);
    localparam logic [HCW-1:0] c_HOLD_ONE  = HCW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [BCW-1:0]   r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_rxs;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
`endif

    assign w_rxs = r_sync[1];

    // Receiver: every sample is taken mid-bit, anchored on the start-bit midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync    <= {r_sync[0], uart_rx};
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ w_rxs;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                frame_err <= 1'b1;
                            end else begin
                                rx_valid <= 1'b1;
                                rx_data  <= r_shift;
                            end
`else
                            rx_valid <= 1'b1;
                            rx_data  <= r_shift;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hold counters: index 0 p1_up, 1 p1_down, 2 p2_up, 3 p2_down.
    logic           w_cmd_clr;
    logic [3:0]     w_cmd_load;
    logic [HCW-1:0] r_hold     [4];
    logic [HCW-1:0] w_hold_nxt [4];

    always_comb begin
        w_cmd_clr  = 1'b0;
        w_cmd_load = 4'b0000;
        if (rx_valid) begin
            case (rx_data)
                8'h77, 8'h57: w_cmd_load = 4'b0001;
                8'h73, 8'h53: w_cmd_load = 4'b0010;
                8'h69, 8'h49: w_cmd_load = 4'b0100;
                8'h6B, 8'h4B: w_cmd_load = 4'b1000;
                8'h20:        w_cmd_clr  = 1'b1;
                default:      w_cmd_load = 4'b0000;
            endcase
        end
    end

    // A load also clears the partner counter so a player's up/down never overlap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_hold_nxt[i] = (r_hold[i] != '0) ? (r_hold[i] - c_HOLD_ONE) : '0;
        end
        if (w_cmd_clr) begin
            for (int i = 0; i < 4; i++) begin
                w_hold_nxt[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_cmd_load[i]) begin
                    w_hold_nxt[i]     = c_HOLD;
                    w_hold_nxt[i ^ 1] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
            p1_up   <= 1'b0;
            p1_down <= 1'b0;
            p2_up   <= 1'b0;
            p2_down <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
            p1_up   <= (w_hold_nxt[0] != '0);
            p1_down <= (w_hold_nxt[1] != '0);
            p2_up   <= (w_hold_nxt[2] != '0);
            p2_down <= (w_hold_nxt[3] != '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_paddle_rx.sv
// ============================================================================
//  Module   : tb_uart_paddle_rx
//  Function : Scoreboard bench for uart_paddle_rx (10 clk/bit, hold 50; a
//             second instance with hold 150 exposes command overlap).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_paddle_rx;

    localparam int BIT_CLKS = 10;
    localparam int HOLD     = 50;
    localparam int HOLD2    = 150;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_valid, frame_err, p1_up, p1_down, p2_up, p2_down;
    logic [7:0] rx_data;
    logic       rx_valid2, frame_err2, q1_up, q1_down, q2_up, q2_down;
    logic [7:0] rx_data2;

    uart_paddle_rx #(.CLK_HZ(1000000), .BAUD(100000), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_err(frame_err), .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down)
    );

    uart_paddle_rx #(.CLK_HZ(1000000), .BAUD(100000), .HOLD_CYCLES(HOLD2)) dut2 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .frame_err(frame_err2), .p1_up(q1_up), .p1_down(q1_down), .p2_up(q2_up), .p2_down(q2_down)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pulses = 0;
    logic both_high = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (p1_up && p1_down || p2_up && p2_down || q1_up && q1_down || q2_up && q2_down)
                both_high = 1'b1;
            if (rx_valid || frame_err) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {23'd0, frame_err, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_both", {31'd0, rx_valid & frame_err}, 32'd0);
                    if (e.is_err) chk("frame_err", {31'd0, frame_err}, 32'd1);
                    else chk("rx_data", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, e.data});
                end
            end
        end
    end

    function automatic logic sel(input int idx);
        case (idx)
            0: return p1_up;
            1: return p1_down;
            2: return p2_up;
            default: return p2_down;
        endcase
    endfunction

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Leaves the line at the stop level; the receiver samples it mid-bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        exp_t e;
        e.is_err = !stop_ok || !par_ok;
        e.data   = b;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^b : ~^b);
`endif
        uart_rx = stop_ok;
    endtask

    task automatic wait_pulse(input string name);
        int n;
        n = 0;
        while (!(rx_valid || frame_err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Call at the negedge showing rx_valid; checks rise next cycle and hold length.
    task automatic check_hold(input int idx, input string name);
        int   n;
        logic others;
        others = 1'b0;
        n = 0;
        @(negedge clk);
        chk({name, "_rise"}, {31'd0, sel(idx)}, 32'd1);
        while (sel(idx) && n < 200) begin
            for (int j = 0; j < 4; j++) if (j != idx) others |= sel(j);
            n++;
            @(negedge clk);
        end
        chk({name, "_len"}, n, HOLD);
        chk({name, "_others"}, {31'd0, others}, 32'd0);
    endtask

    initial begin
        int pulses_before;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {rx_valid, frame_err, rx_data, p1_up, p1_down, p2_up, p2_down}, 32'd0);
        repeat (200) @(negedge clk);
        chk("idle_outputs", {n_pulses[7:0], p1_up, p1_down, p2_up, p2_down}, 32'd0);

        send_byte(8'h77, 1'b1, 1'b1);
        wait_pulse("w");
        chk("w_not_yet", {31'd0, p1_up}, 32'd0);
        check_hold(0, "p1_up");

        // Back-to-back 's','w',' ' judged on the long-hold instance.
        send_byte(8'h73, 1'b1, 1'b1);
        wait_pulse("s");
        @(negedge clk);
        chk("q1_down_rise", {30'd0, q1_up, q1_down}, 32'd1);
        send_byte(8'h77, 1'b1, 1'b1);
        wait_pulse("w2");
        chk("q1_before_swap", {30'd0, q1_up, q1_down}, 32'd1);
        @(negedge clk);
        chk("q1_after_swap", {30'd0, q1_up, q1_down}, 32'd2);
        send_byte(8'h20, 1'b1, 1'b1);
        wait_pulse("space");
        chk("q1_before_clr", {30'd0, q1_up, q1_down}, 32'd2);
        @(negedge clk);
        chk("q_after_clr", {28'd0, q1_up, q1_down, q2_up, q2_down}, 32'd0);
        repeat (60) @(negedge clk);

        pulses_before = n_pulses;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_pulse", n_pulses, pulses_before);

        pulses_before = n_pulses;
        send_byte(8'h41, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_one_err", n_pulses, pulses_before + 1);
        send_byte(8'h49, 1'b1, 1'b1);
        wait_pulse("I");
        check_hold(2, "p2_up");

        // Abort 'k' (0x6B) during data bit 4.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h6B >> i) & 1));
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_state", {rx_data, p1_up, p1_down, p2_up, p2_down}, 32'd0);
        send_byte(8'h6B, 1'b1, 1'b1);
        wait_pulse("k");
        check_hold(3, "p2_down");

`ifdef UART_RX_PARITY_EN
        send_byte(8'h6B, 1'b1, 1'b0);
        wait_pulse("k_par");
        repeat (10) @(negedge clk);
        chk("par_no_p2_down", {31'd0, p2_down}, 32'd0);
`endif

        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("never_both_high", {31'd0, both_high}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
